tube_display_driver: RTL and testbench

//  Downstream consumer of the CPU datapath's reg_map_tube word: drives the 8-digit multiplexed 7-segment tube.

---
 rtl/tube_display_driver.sv | 185 ++++++++++++++++++
 tb/tb_tube_display_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tube_display_driver.sv
// tube_display_driver
// Watches the datapath's tube word. When the value or the mode changes, it converts
// the value to eight digit glyphs: raw nibbles in hex, or double-dabble BCD in decimal.
// The glyphs are committed together in one cycle, so a half-converted value is never shown.
// A free-running scanner multiplexes the committed glyphs onto an/seg.
module tube_display_driver #(
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] tube_data,
   input  logic        dec_mode,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        busy
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t            state_reg, state_next;

   logic [31:0]       shadow_reg;
   logic              mode_reg;
   logic              valid_reg;
   logic [39:0]       bcd_reg;
   logic [31:0]       bin_reg;
   logic [4:0]        iter_reg;
   logic [63:0]       digit_seg_reg;

   logic [CNT_W-1:0]  scan_cnt_reg;
   logic [2:0]        digit_idx_reg;
   logic [7:0]        an_reg;
   logic [7:0]        seg_reg;

   logic              start_conv;
   logic              conv_last;
   logic              commit;
   logic [39:0]       bcd_adj;
   logic [39:0]       bcd_shift;
   logic [31:0]       bin_shift;
   logic              overflow;
   logic [7:0]        nz;
   logic [63:0]       render_seg;
   logic              unused_bcd_top;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'h0:    g = 8'h3F;
         4'h1:    g = 8'h06;
         4'h2:    g = 8'h5B;
         4'h3:    g = 8'h4F;
         4'h4:    g = 8'h66;
         4'h5:    g = 8'h6D;
         4'h6:    g = 8'h7D;
         4'h7:    g = 8'h07;
         4'h8:    g = 8'h7F;
         4'h9:    g = 8'h6F;
         4'hA:    g = 8'h77;
         4'hB:    g = 8'h7C;
         4'hC:    g = 8'h39;
         4'hD:    g = 8'h5E;
         4'hE:    g = 8'h79;
         default: g = 8'h71;
      endcase
      return g;
   endfunction

   // A new conversion starts only from IDLE, when nothing valid is shown or the input moved.
   assign start_conv = (state_reg == IDLE) &&
                       (!valid_reg || (tube_data != shadow_reg) || (dec_mode != mode_reg));
   assign conv_last  = !mode_reg || (iter_reg == 5'd31);
   assign commit     = (state_reg == DONE);

   // Double-dabble step: add 3 to every BCD nibble >= 5, then shift the BCD/binary pair left.
   for (genvar gi = 0; gi < 10; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                : bcd_reg[4*gi +: 4];
   end
   assign bcd_shift      = {bcd_adj[38:0], bin_reg[31]};
   assign bin_shift      = {bin_reg[30:0], 1'b0};
   // A 32-bit value never needs more than 39 BCD bits, so the top adjusted bit is dropped.
   assign unused_bcd_top = bcd_adj[39];

   // Glyph rendering of the finished conversion, including overflow dashes and zero blanking.
   assign overflow = mode_reg && (shadow_reg > 32'd99_999_999);
   for (genvar gi = 0; gi < 8; gi++) begin : g_render
      logic [3:0] nib;
      logic       shown;
      assign nib    = bcd_reg[4*gi +: 4];
      assign nz[gi] = (nib != 4'd0);
      assign shown  = !mode_reg || !BLANK_LZ || (gi == 0) || (|nz[7:gi]);
      assign render_seg[8*gi +: 8] = overflow ? 8'h40 : (shown ? glyph(nib) : 8'h00);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // FSM next state and busy flag.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_conv) state_next = CONVERT;
         end
         CONVERT: begin
            busy = 1'b1;
            if (conv_last) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Conversion datapath: latch the input, run the conversion, commit all glyphs at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_reg    <= '0;
         mode_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         bcd_reg       <= '0;
         bin_reg       <= '0;
         iter_reg      <= '0;
         digit_seg_reg <= '0;
      end else begin
         if (start_conv) begin
            shadow_reg <= tube_data;
            mode_reg   <= dec_mode;
            bcd_reg    <= '0;
            bin_reg    <= tube_data;
            iter_reg   <= '0;
         end else if (state_reg == CONVERT) begin
            if (mode_reg) begin
               bcd_reg  <= bcd_shift;
               bin_reg  <= bin_shift;
               iter_reg <= iter_reg + 5'd1;
            end else begin
               bcd_reg  <= {8'h00, shadow_reg};
            end
         end
         if (commit) begin
            digit_seg_reg <= render_seg;
            valid_reg     <= 1'b1;
         end
      end
   end

   // Digit scanner: each digit stays lit SCAN_DIV cycles; an and seg register together.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_reg  <= '0;
         digit_idx_reg <= '0;
         an_reg        <= '0;
         seg_reg       <= '0;
      end else begin
         an_reg  <= 8'b1 << digit_idx_reg;
         seg_reg <= digit_seg_reg[{digit_idx_reg, 3'b000} +: 8];
         if (scan_cnt_reg == CNT_MAX) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= digit_idx_reg + 3'd1;
         end else begin
            scan_cnt_reg  <= scan_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;

endmodule

// File: tb/tb_tube_display_driver.sv
// Bench for tube_display_driver: a value-level model of the display (what each digit must
// show, when a commit lands, which digit is lit) is compared with the DUT every cycle,
// and directed tests pin the model with hand-computed glyphs.
module tb_tube_display_driver;

   localparam int SCAN = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] tube_data = 32'h0;
   logic        dec_mode = 1'b0;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        busy;

   tube_display_driver #(.SCAN_DIV(SCAN), .BLANK_LZ(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .tube_data (tube_data),
      .dec_mode  (dec_mode),
      .an        (an),
      .seg       (seg),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int busy_cnt = 0;

   logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // What the eight digits must show for a value, from plain arithmetic.
   function automatic logic [63:0] render(input logic [31:0] v, input logic dm);
      logic [63:0]     r;
      longint unsigned p;
      int              d;
      r = '0;
      if (!dm) begin
         for (int i = 0; i < 8; i++) begin
            d = int'((v >> (4 * i)) & 32'hF);
            r[8*i +: 8] = glyph_tab[d];
         end
      end else if (v > 32'd99_999_999) begin
         for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'h40;
      end else begin
         p = 1;
         for (int i = 0; i < 8; i++) begin
            if (i == 0 || longint'(v) >= p) begin
               d = int'((longint'(v) / p) % 10);
               r[8*i +: 8] = glyph_tab[d];
            end
            p = p * 10;
         end
      end
      return r;
   endfunction

   // Model: conversion takes 2 cycles (hex) or 33 cycles (dec) from detection to commit;
   // the lit digit is (cycles since reset / SCAN) mod 8 and shows the digits committed so far.
   int          n_run;
   int          m_idx;
   int          m_left;
   bit          m_valid, m_mode, m_pend;
   logic [31:0] m_shadow;
   logic [63:0] m_dig;
   logic [7:0]  m_an, m_seg;
   logic        m_busy;

   always @(posedge clk) begin
      if (reset) begin
         m_an = 8'h00; m_seg = 8'h00; m_busy = 1'b0;
         m_valid = 1'b0; m_pend = 1'b0; m_dig = '0; n_run = 0;
         m_shadow = '0; m_mode = 1'b0; m_left = 0;
      end else begin
         m_idx = (n_run / SCAN) % 8;
         m_an  = 8'(1 << m_idx);
         m_seg = m_dig[8*m_idx +: 8];
         n_run++;
         if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
               m_dig   = render(m_shadow, m_mode);
               m_valid = 1'b1;
               m_pend  = 1'b0;
            end
         end else if (!m_valid || tube_data != m_shadow || dec_mode != m_mode) begin
            m_shadow = tube_data;
            m_mode   = dec_mode;
            m_pend   = 1'b1;
            m_left   = dec_mode ? 33 : 2;
         end
         m_busy = m_pend;
      end
   end

   // Every-cycle comparison of the DUT outputs with the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("an",   {56'h0, an},   {56'h0, m_an});
         check("seg",  {56'h0, seg},  {56'h0, m_seg});
         check("busy", {63'h0, busy}, {63'h0, m_busy});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
      end
   endtask

   // Watch the scan until each digit is lit and compare its glyph with the literal.
   task automatic expect_digits(input string tag, input logic [63:0] e);
      int w;
      check({tag, " model"}, m_dig, e);
      for (int i = 0; i < 8; i++) begin
         w = 0;
         while (an !== 8'(1 << i) && w < 4 * 8 * SCAN) begin
            @(negedge clk);
            w++;
         end
         check($sformatf("%s an%0d", tag, i), {56'h0, an}, {56'h0, 8'(1 << i)});
         check($sformatf("%s digit%0d", tag, i), {56'h0, seg}, {56'h0, e[8*i +: 8]});
      end
   endtask

   task automatic dec_case(input string tag, input logic [31:0] v, input logic [63:0] e);
      tube_data = v;
      busy_cnt  = 0;
      step(50);
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
      expect_digits(tag, e);
      $display("%s: dec %0d -> %h", tag, v, e);
   endtask

   int hold;

   initial begin
      // Test 1: hex 0xAB straight out of reset
      reset = 1'b1; dec_mode = 1'b0; tube_data = 32'h0000_00AB;
      @(negedge clk);
      chk_en = 1'b1;
      check("reset an",   {56'h0, an},   64'h0);
      check("reset seg",  {56'h0, seg},  64'h0);
      check("reset busy", {63'h0, busy}, 64'h0);
      step(2);
      reset = 1'b0;
      busy_cnt = 0;
      step(40);
      check("t1 busy cycles", 64'(busy_cnt), 64'd2);
      expect_digits("t1", {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h77, 8'h7C});
      $display("t1: hex 000000ab -> digits ab");

      // Test 2: decimal 12345
      dec_mode = 1'b1;
      dec_case("t2", 32'd12345, {8'h00, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D});

      // Test 3: overflow, largest in range, zero
      dec_case("t3a", 32'd100_000_000, {8{8'h40}});
      dec_case("t3b", 32'd99_999_999,  {8{8'h6F}});
      dec_case("t3c", 32'd0,           {56'h0, 8'h3F});

      // Test 4: value changes mid-conversion; the old value commits, then the new one
      tube_data = 32'd12345;
      busy_cnt  = 0;
      step(10);
      tube_data = 32'd7;
      step(80);
      check("t4 busy cycles", 64'(busy_cnt), 64'd66);
      expect_digits("t4", {56'h0, 8'h07});
      $display("t4: 12345 then 7 -> final 7");

      // Test 5: each digit held exactly SCAN cycles, in order
      hold = 0;
      while (an !== 8'h02 && hold < 4 * 8 * SCAN) begin @(negedge clk); hold++; end
      hold = 0;
      while (an === 8'h02 && hold < 4 * SCAN) begin @(negedge clk); hold++; end
      check("t5 hold cycles", 64'(hold), 64'(SCAN));
      check("t5 next digit", {56'h0, an}, 64'h04);
      $display("t5: digit 1 lit for %0d cycles", hold);

      // Test 6: reset in the middle of a decimal conversion
      tube_data = 32'd54321;
      step(15);
      reset = 1'b1;
      step(1);
      check("t6 an",   {56'h0, an},   64'h0);
      check("t6 seg",  {56'h0, seg},  64'h0);
      check("t6 busy", {63'h0, busy}, 64'h0);
      reset = 1'b0;
      busy_cnt = 0;
      step(50);
      check("t6 busy cycles", 64'(busy_cnt), 64'd33);
      expect_digits("t6", {8'h00, 8'h00, 8'h00, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06});
      $display("t6: reset mid-conversion, 54321 reconverted");

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
